pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: cycles pll_rst is held high per attempt (min 1).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (min 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: WAIT_LOCK cycles before a retry (min 2).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: retries before FAIL.
REQ-005 SHALL have port refclk, input, 1: the single clock (PLL reference clock domain).
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port pll_locked, input, 1: raw asynchronous PLL locked flag.
REQ-008 SHALL have port soft_rst, input, 1: one-cycle request to restart the whole sequence.
REQ-009 SHALL have port pll_rst, output, 1: PLL reset drive.
REQ-010 SHALL have port sys_rst, output, 1: downstream core reset, high until clocks are stable.
REQ-011 SHALL have port ready, output, 1: high only in RUN.
REQ-012 SHALL have port fail, output, 1: lock never achieved within MAX_RETRIES retries.
REQ-013 SHALL have port retry_cnt, output, 4: retries in the current sequence.
REQ-014 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s), adding 2 cycles of latency; every output SHALL be registered.
REQ-016 States SHALL be PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAIL, sharing one cycle counter that is cleared on every state change.
REQ-017 PLL_RESET: pll_rst=1, sys_rst=1; after RESET_CYCLES cycles in this state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, sys_rst=1; locked_s=1 -> STABILIZE.
REQ-019 STABILIZE: locked_s=1 for STABLE_CYCLES consecutive cycles -> RUN; any locked_s=0 -> WAIT_LOCK, count restarts.
REQ-020 RUN: sys_rst=0, ready=1, pll_rst=0; locked_s=0 -> lock_loss_cnt+1 (saturates at 255), retry_cnt cleared, -> PLL_RESET.
REQ-021 FAIL: pll_rst=1, sys_rst=1, fail=1, ready=0; only rst exits.
REQ-022 soft_rst=1 in any state except FAIL SHALL -> PLL_RESET and clear retry_cnt; it takes priority over every other transition in the same cycle.
REQ-023 soft_rst and a locked_s drop in RUN in the same cycle SHALL still increment lock_loss_cnt.
REQ-024 sys_rst SHALL be high in every cycle where ready=0.

Reset
REQ-025 rst=1 SHALL synchronously force: PLL_RESET, counter=0, synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0.
REQ-026 rst asserted mid-sequence SHALL abandon the sequence with no extra cycle.

Configuration
REQ-027 Macro PLL_LOCK_TIMEOUT_EN defined: after TIMEOUT_CYCLES cycles in WAIT_LOCK without lock -> if retry_cnt<MAX_RETRIES then retry_cnt+1 and PLL_RESET, else FAIL.
REQ-028 Macro PLL_LOCK_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely; FAIL is unreachable; fail and retry_cnt are tied to 0.

Structure
REQ-029 A shared package SHALL hold the state enum type and the default cycle constants.
REQ-030 The synchronizer SHALL be a sub-module named sync_2ff.

Verification (RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=16, MAX_RETRIES=2, macro defined)
REQ-031 Release rst with pll_locked=1 constantly -> pll_rst low 4 cycles after reset; sys_rst falls and ready rises 2+8 cycles after WAIT_LOCK entry.
REQ-032 pll_locked glitches low for 1 cycle during STABILIZE -> back to WAIT_LOCK; release occurs a full 8 locked_s cycles later.
REQ-033 pll_locked held 0 -> two retries (retry_cnt 1, then 2), then FAIL with fail=1, pll_rst=1; only rst recovers.
REQ-034 In RUN, drop pll_locked -> 2 cycles later sys_rst=1, ready=0, lock_loss_cnt=1, pll_rst pulses 4 cycles.
REQ-035 soft_rst pulse in RUN together with a lock drop -> PLL_RESET and lock_loss_cnt increments; 256 lock losses -> lock_loss_cnt stays 255.
REQ-036 Macro undefined, pll_locked=0 for 100 cycles -> stays in WAIT_LOCK, fail=0, retry_cnt=0.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int DEF_RESET_CYCLES   = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer with retry, lock-loss counting and registered outputs.
// Define PLL_LOCK_TIMEOUT_EN to enable the WAIT_LOCK timeout, retries and the FAIL state.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max3(RESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES) + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic             locked_s;
  logic             timeout_hit;
  logic             restart;

  sync_2ff u_sync (
    .clk  (refclk),
    .srst (rst),
    .d_i  (pll_locked),
    .q_o  (locked_s)
  );

`ifdef PLL_LOCK_TIMEOUT_EN
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign restart = soft_rst && (state_q != ST_FAIL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    // A lock drop in RUN is counted even when a soft restart wins the transition.
    if (state_q == ST_RUN && !locked_s && loss_q != 8'hFF)
      loss_d = loss_q + 8'd1;

    case (state_q)
      ST_PLL_RESET: if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end else if (timeout_hit) begin
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_PLL_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STABILIZE: begin
        if (!locked_s)                                 state_d = ST_WAIT_LOCK;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1))   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          retry_d = 4'd0;
          state_d = ST_PLL_RESET;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_PLL_RESET;
    endcase

    if (restart) begin
      state_d = ST_PLL_RESET;
      retry_d = 4'd0;
    end

    if (state_d != state_q || restart)
      cnt_d = '0;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
      sys_rst_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule
